maxnet_iterator: RTL
====================

// Module: maxnet_iterator
// PURPOSE
//  Producer side of the MaxNet winner-check interface: accepts 4 activations + 4 labels via valid/ready,
//  runs lateral-inhibition iterations (one per cycle), drives x1..x4/a1..a4 to the output checker and
//  stops when the checker's valid (chk_valid) asserts or MAX_ITER is hit; returns winner label via valid/ready.
// PARAMETERS
//  DATA_W    32     activation/label width; bit DATA_W-1 = sign, [DATA_W-2:0] = unsigned magnitude
//  FRAC      16     fractional bits of magnitude (Q15.16)
//  EPS       16384  inhibition weight, Q0.FRAC (16384 = 0.25); must be < 2^FRAC/3 for convergence
//  MAX_ITER  64     iteration limit before timeout
//  ITER_W    7      iteration counter width, >= clog2(MAX_ITER+1)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous active-high reset
//  in_valid     in   1       input bundle valid
//  in_ready     out  1       block can accept bundle (IDLE only)
//  in_x1..4     in   DATA_W  initial activations
//  in_a1..4     in   DATA_W  labels
//  x1..x4       out  DATA_W  current activations to checker (registered)
//  a1..a4       out  DATA_W  current labels to checker (registered)
//  chk_valid    in   1       checker result: all-zero or exactly-one-nonzero, combinational from x1..x4
//  out_valid    out  1       result valid
//  out_ready    in   1       result consumer ready
//  winner       out  DATA_W  label of the single nonzero activation; 0 if none
//  no_winner    out  1       converged to all-zero (ties or all-zero input)
//  timeout      out  1       MAX_ITER reached without chk_valid
//  iter_cnt     out  ITER_W  iterations performed
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except in_ready=1. rst mid-ITER/DONE aborts, no result emitted.
//  FSM IDLE -> ITER -> DONE -> IDLE.
//  IDLE: in_ready=1. in_valid&in_ready: load x_i <= (in_x_i[31] ? 0 : {1'b0,in_x_i[30:0]}), a_i <= in_a_i,
//    iter_cnt<=0, -> ITER. Negative activations clamp to 0.
//  ITER (in_ready=0), priority per cycle:
//    1) chk_valid=1 -> DONE; x unchanged, iter_cnt unchanged.
//    2) else iter_cnt==MAX_ITER -> DONE with timeout=1.
//    3) else update all lanes simultaneously, iter_cnt++.
//  Lane update: S = x1+x2+x3+x4 (DATA_W+1 bits, no overflow);
//    inh_i = ((S - x_i) * EPS) >> FRAC (full-width product, truncate); x_i' = (inh_i >= x_i) ? 0 : x_i - inh_i.
//    Bit 31 of x_i always 0 after load.
//  DONE entry registers: winner = a_k of the unique k with x_k[30:0]!=0, else 0; no_winner = all x zero
//    and !timeout. timeout winner = 0.
//  DONE: out_valid=1, results stable until out_valid&out_ready, then -> IDLE same edge; out_valid=0 next cycle.
//  Latency: load edge to DONE = iter_cnt+1 cycles; min 2 cycles load->out_valid.
//  x/a outputs hold last values in DONE and IDLE until next load.
//  chk_valid sampled only in ITER; ignored elsewhere.
//  Ties: equal nonzero maxima decay together; truncation can stall at small nonzero -> timeout.
// STRUCTURE
//  maxnet_pkg: DATA_W, FRAC defaults, state_t enum {IDLE,ITER,DONE}, Q15.16 helper constants.
//  Sub-module maxnet_lane (x_i, S -> x_i'), instantiated 4x; FSM, counter, winner select in top.
// TESTING  (EPS=0.25, MAX_ITER=64, values Q15.16 hex)
//  x={40000,10000,0,0}, a={A,B,C,D} -> iter1 x={3C000,0,0,0}; out winner=A, iter_cnt=1, no_winner=0, timeout=0
//  x={0,0,0,0} -> chk_valid first ITER cycle; winner=0, no_winner=1, iter_cnt=0
//  x={0,0,30000,0}, a3=7 -> winner=7, iter_cnt=0, out_valid 2 cycles after load
//  x={20000,20000,0,0} -> timeout=1, winner=0, iter_cnt=64, x1==x2 nonzero
//  in_x1=80000001 (negative), x2=10000 -> x1 loaded 0; winner=a2, iter_cnt=0
//  rst at ITER iter 1 -> next cycle IDLE, in_ready=1, out_valid=0; out_ready=0 holds results 5 cycles stable

Source files
------------

// File: rtl/maxnet_iterator_pkg.sv
// Shared definitions for the MaxNet winner-check iterator.
//   DATA_W  : activation/label width (sign bit + Q15.16 magnitude)
//   FRAC    : fractional bits of the magnitude
//   ITER_W  : iteration counter width
//   state_t : iterator FSM states
//   clamp_neg() : maps negative activations to zero on load
package maxnet_iterator_pkg;

   localparam int unsigned DATA_W           = 32;
   localparam int unsigned FRAC             = 16;
   localparam int unsigned ITER_W           = 7;
   localparam int unsigned NUM_LANES        = 4;
   // Inhibition weight in Q0.FRAC; 16384 = 0.25.
   localparam int unsigned EPS_DEFAULT      = 16384;
   localparam int unsigned MAX_ITER_DEFAULT = 64;

   typedef enum logic [1:0] {
      StIdle,
      StIter,
      StDone
   } state_t;

   function automatic logic [DATA_W-1:0] clamp_neg(input logic [DATA_W-1:0] v);
      return v[DATA_W-1] ? '0 : v;
   endfunction

endpackage

// File: rtl/maxnet_iterator_if.sv
// Bundle between the MaxNet iterator and its environment.
//   in_*      : input bundle handshake (activations + labels)
//   x*, a*    : current activations/labels presented to the winner checker
//   chk_valid : checker verdict (all-zero or exactly one nonzero)
//   out_*     : result handshake with winner / no_winner / timeout / iter_cnt
// master = iterator, slave = environment.
interface maxnet_iterator_if;
   import maxnet_iterator_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_x1, in_x2, in_x3, in_x4;
   logic [DATA_W-1:0] in_a1, in_a2, in_a3, in_a4;
   logic [DATA_W-1:0] x1, x2, x3, x4;
   logic [DATA_W-1:0] a1, a2, a3, a4;
   logic              chk_valid;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] winner;
   logic              no_winner;
   logic              timeout;
   logic [ITER_W-1:0] iter_cnt;

   modport master (
      input  in_valid, in_x1, in_x2, in_x3, in_x4, in_a1, in_a2, in_a3, in_a4,
      input  chk_valid, out_ready,
      output in_ready, x1, x2, x3, x4, a1, a2, a3, a4,
      output out_valid, winner, no_winner, timeout, iter_cnt
   );

   modport slave (
      output in_valid, in_x1, in_x2, in_x3, in_x4, in_a1, in_a2, in_a3, in_a4,
      output chk_valid, out_ready,
      input  in_ready, x1, x2, x3, x4, a1, a2, a3, a4,
      input  out_valid, winner, no_winner, timeout, iter_cnt
   );

endinterface

// File: rtl/maxnet_iterator_lane.sv
// One lateral-inhibition lane: x' = max(0, x - ((S - x) * EPS) >> FRAC).
//   x      : current activation (non-negative)
//   sum    : sum of all four activations (one extra bit, cannot overflow)
//   x_next : updated activation
module maxnet_iterator_lane #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned FRAC   = 16,
   parameter int unsigned EPS    = 16384
) (
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W:0]   sum,
   output logic [DATA_W-1:0] x_next
);

   localparam int unsigned PW = DATA_W + 1 + FRAC;

   logic [DATA_W:0] others;
   logic [PW-1:0]   prod;
   logic [PW-1:0]   inh;

   always_comb begin
      others = sum - {1'b0, x};
      // Full-width product so no magnitude bits are lost before truncation.
      prod   = PW'(others) * PW'(EPS);
      inh    = prod >> FRAC;
      x_next = (inh >= PW'(x)) ? '0 : x - inh[DATA_W-1:0];
   end

endmodule

// File: rtl/maxnet_iterator.sv
// MaxNet iterator: loads four activations and labels, applies one inhibition step
// per cycle until the external checker reports a decision or MAX_ITER is reached,
// then offers the winner label through a valid/ready result handshake.
//   clk, rst : clock and synchronous active-high reset
//   bus      : maxnet_iterator_if master (input bundle, checker link, result)
module maxnet_iterator
   import maxnet_iterator_pkg::*;
#(
   parameter int unsigned EPS      = EPS_DEFAULT,
   parameter int unsigned MAX_ITER = MAX_ITER_DEFAULT
) (
   input logic               clk,
   input logic               rst,
   maxnet_iterator_if.master bus
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] x_q [NUM_LANES];
   logic [DATA_W-1:0] x_d [NUM_LANES];
   logic [DATA_W-1:0] a_q [NUM_LANES];
   logic [DATA_W-1:0] a_d [NUM_LANES];
   logic [DATA_W-1:0] x_nxt [NUM_LANES];
   logic [DATA_W-1:0] in_x [NUM_LANES];
   logic [DATA_W-1:0] in_a [NUM_LANES];
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [DATA_W-1:0] winner_q, winner_d;
   logic              no_winner_q, no_winner_d;
   logic              timeout_q, timeout_d;
   logic [DATA_W:0]   sum;
   logic [NUM_LANES-1:0] nz;
   logic [2:0]        nz_cnt;
   logic [DATA_W-1:0] sel_winner;

   assign in_x[0] = bus.in_x1;
   assign in_x[1] = bus.in_x2;
   assign in_x[2] = bus.in_x3;
   assign in_x[3] = bus.in_x4;
   assign in_a[0] = bus.in_a1;
   assign in_a[1] = bus.in_a2;
   assign in_a[2] = bus.in_a3;
   assign in_a[3] = bus.in_a4;

   assign sum = {1'b0, x_q[0]} + {1'b0, x_q[1]} + {1'b0, x_q[2]} + {1'b0, x_q[3]};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      maxnet_iterator_lane #(
         .DATA_W (DATA_W),
         .FRAC   (FRAC),
         .EPS    (EPS)
      ) u_lane (
         .x      (x_q[i]),
         .sum    (sum),
         .x_next (x_nxt[i])
      );
   end

   // Winner is the label of the only nonzero lane; anything else yields 0.
   always_comb begin
      nz_cnt     = '0;
      sel_winner = '0;
      nz         = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         nz[i] = |x_q[i][DATA_W-2:0];
         if (nz[i]) begin
            nz_cnt     = nz_cnt + 3'd1;
            sel_winner = a_q[i];
         end
      end
      if (nz_cnt != 3'd1) sel_winner = '0;
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      a_d         = a_q;
      iter_d      = iter_q;
      winner_d    = winner_q;
      no_winner_d = no_winner_q;
      timeout_d   = timeout_q;
      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               for (int i = 0; i < NUM_LANES; i++) begin
                  x_d[i] = clamp_neg(in_x[i]);
                  a_d[i] = in_a[i];
               end
               iter_d      = '0;
               winner_d    = '0;
               no_winner_d = 1'b0;
               timeout_d   = 1'b0;
               state_d     = StIter;
            end
         end
         StIter: begin
            if (bus.chk_valid) begin
               winner_d    = sel_winner;
               no_winner_d = ~|nz;
               state_d     = StDone;
            end else if (iter_q == ITER_W'(MAX_ITER)) begin
               winner_d    = '0;
               no_winner_d = 1'b0;
               timeout_d   = 1'b1;
               state_d     = StDone;
            end else begin
               x_d    = x_nxt;
               iter_d = iter_q + 1'b1;
            end
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         iter_q      <= '0;
         winner_q    <= '0;
         no_winner_q <= 1'b0;
         timeout_q   <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) begin
            x_q[i] <= '0;
            a_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         iter_q      <= iter_d;
         winner_q    <= winner_d;
         no_winner_q <= no_winner_d;
         timeout_q   <= timeout_d;
         x_q         <= x_d;
         a_q         <= a_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.winner    = winner_q;
   assign bus.no_winner = no_winner_q;
   assign bus.timeout   = timeout_q;
   assign bus.iter_cnt  = iter_q;
   assign bus.x1        = x_q[0];
   assign bus.x2        = x_q[1];
   assign bus.x3        = x_q[2];
   assign bus.x4        = x_q[3];
   assign bus.a1        = a_q[0];
   assign bus.a2        = a_q[1];
   assign bus.a3        = a_q[2];
   assign bus.a4        = a_q[3];

endmodule
